branch_resolve: RTL and testbench

Execute-stage branch resolution unit. Takes each branch leaving ex0 together with the prediction it was fetched under and decides whether that prediction was correct. It produces the registered `fact_*` / `predict_*_fail` update bundle consumed by the IF0 BTB and the redirect that restarts fetch. After a redirect it squashes wrong-path instructions still in flight until the correct-path PC arrives.

---
 rtl/branch_resolve_if.sv | 49 ++++
 rtl/branch_resolve.sv | 155 +++++++++++++++
 tb/tb_branch_resolve.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// ----------------------------------------------------------------------------
// branch_resolve_if
//   Bundle between ex0 and the branch resolution unit. It carries:
//     - ex0 side (master drives): ex_valid, ex_ready, ex_pc, ex_btype, ex_cond,
//       ex_target, ex_pred_taken, ex_pred_pc
//     - resolution side (slave drives): ex_kill, the fact_* / predict_*_fail
//       BTB update bundle, redirect_valid / redirect_pc, br_cnt / miss_cnt
//   CNT_WIDTH must match the CNT_WIDTH of the branch_resolve instance.
// ----------------------------------------------------------------------------
interface branch_resolve_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 ex_valid;
    logic                 ex_ready;
    logic [31:0]          ex_pc;
    logic [1:0]           ex_btype;
    logic                 ex_cond;
    logic [31:0]          ex_target;
    logic                 ex_pred_taken;
    logic [31:0]          ex_pred_pc;

    logic                 ex_kill;
    logic                 fact_valid;
    logic [31:0]          fact_pc;
    logic [31:0]          fact_tpc;
    logic                 fact_taken;
    logic                 predict_dir_fail;
    logic                 predict_add_fail;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [CNT_WIDTH-1:0] br_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;

    modport master (
        output ex_valid, ex_ready, ex_pc, ex_btype, ex_cond, ex_target,
               ex_pred_taken, ex_pred_pc,
        input  ex_kill, fact_valid, fact_pc, fact_tpc, fact_taken,
               predict_dir_fail, predict_add_fail, redirect_valid,
               redirect_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  ex_valid, ex_ready, ex_pc, ex_btype, ex_cond, ex_target,
               ex_pred_taken, ex_pred_pc,
        output ex_kill, fact_valid, fact_pc, fact_tpc, fact_taken,
               predict_dir_fail, predict_add_fail, redirect_valid,
               redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// ----------------------------------------------------------------------------
// branch_resolve
//   Execute-stage branch resolution. Compares the actual outcome of each
//   instruction leaving ex0 with the prediction it was fetched under, produces
//   the registered BTB update bundle and a one-cycle fetch redirect, and after
//   a redirect kills wrong-path instructions until the correct-path PC shows up.
//
// Ports:
//   clk   - clock
//   rstn  - asynchronous active-low reset
//   br    - branch_resolve_if.slave
//             in : ex_valid, ex_ready, ex_pc, ex_btype, ex_cond, ex_target,
//                  ex_pred_taken, ex_pred_pc
//             out: ex_kill (combinational), fact_valid, fact_pc, fact_tpc,
//                  fact_taken, predict_dir_fail, predict_add_fail,
//                  redirect_valid, redirect_pc, br_cnt, miss_cnt (registered)
// ----------------------------------------------------------------------------
module branch_resolve #(
    parameter int CNT_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rstn,
    branch_resolve_if.slave br
);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    localparam logic [1:0] BT_NONE = 2'b00;
    localparam logic [1:0] BT_UNC  = 2'b01;
    localparam logic [1:0] BT_COND = 2'b10;
    localparam logic [1:0] BT_IND  = 2'b11;

    // Registered state
    state_t               r_state;
    logic [31:0]          r_exp_pc;
    logic                 r_fact_valid;
    logic [31:0]          r_fact_pc;
    logic [31:0]          r_fact_tpc;
    logic                 r_fact_taken;
    logic                 r_dir_fail;
    logic                 r_add_fail;
    logic                 r_redirect_valid;
    logic [31:0]          r_redirect_pc;
    logic [CNT_WIDTH-1:0] r_br_cnt;
    logic [CNT_WIDTH-1:0] r_miss_cnt;

    // Combinational resolution terms
    logic [31:0] w_fall;
    logic        w_act_taken;
    logic [31:0] w_act_next;
    logic        w_dir_fail;
    logic        w_add_fail;
    logic        w_mispred;
    logic        w_fire;
    logic        w_kill;
    logic        w_resolve;
    logic        w_is_branch;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] one;
        one = '0;
        one[0] = 1'b1;
        if (&v) begin
            return v;
        end
        return v + one;
    endfunction

    // Sequential fall-through is the next 8-byte fetch group, not pc+4.
    assign w_fall = {br.ex_pc[31:3], 3'b000} + 32'd8;

    always_comb begin
        w_act_taken = 1'b0;
        unique case (br.ex_btype)
            BT_NONE: w_act_taken = 1'b0;
            BT_UNC:  w_act_taken = 1'b1;
            BT_COND: w_act_taken = br.ex_cond;
            BT_IND:  w_act_taken = 1'b1;
            default: w_act_taken = 1'b0;
        endcase
    end

    assign w_act_next  = w_act_taken ? br.ex_target : w_fall;
    assign w_dir_fail  = (w_act_taken != br.ex_pred_taken);
    assign w_add_fail  = w_act_taken & (br.ex_pred_pc != br.ex_target);
    // A not-taken prediction also carries a next-fetch PC; if fetch did not
    // fall through to the next group the wrong-path stream must be restarted.
    assign w_mispred   = w_dir_fail | w_add_fail |
                         (~w_act_taken & ~br.ex_pred_taken & (br.ex_pred_pc != w_fall));
    assign w_is_branch = (br.ex_btype != BT_NONE);

    assign w_fire    = br.ex_valid & br.ex_ready;
    // Kill is independent of ex_ready so a stalled wrong-path op is flagged too.
    assign w_kill    = (r_state == ST_SQUASH) & br.ex_valid & (br.ex_pc != r_exp_pc);
    assign w_resolve = w_fire & ~w_kill;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state          <= ST_NORMAL;
            r_exp_pc         <= '0;
            r_fact_valid     <= 1'b0;
            r_fact_pc        <= '0;
            r_fact_tpc       <= '0;
            r_fact_taken     <= 1'b0;
            r_dir_fail       <= 1'b0;
            r_add_fail       <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_br_cnt         <= '0;
            r_miss_cnt       <= '0;
        end else begin
            // Pulse-type outputs are only high in the cycle after a resolve.
            r_fact_valid     <= w_resolve;
            r_fact_taken     <= w_resolve & w_act_taken;
            r_dir_fail       <= w_resolve & w_dir_fail;
            r_add_fail       <= w_resolve & w_add_fail;
            r_redirect_valid <= w_resolve & w_mispred;

            if (w_resolve) begin
                r_fact_pc  <= br.ex_pc;
                r_fact_tpc <= br.ex_target;
                if (w_is_branch) begin
                    r_br_cnt <= sat_inc(r_br_cnt);
                end
                if (w_mispred) begin
                    r_miss_cnt    <= sat_inc(r_miss_cnt);
                    r_redirect_pc <= w_act_next;
                    r_state       <= ST_SQUASH;
                    r_exp_pc      <= w_act_next;
                end else begin
                    // A clean resolve means fetch is on the correct path,
                    // whether we were squashing or not.
                    r_state <= ST_NORMAL;
                end
            end
        end
    end

    assign br.ex_kill          = w_kill;
    assign br.fact_valid       = r_fact_valid;
    assign br.fact_pc          = r_fact_pc;
    assign br.fact_tpc         = r_fact_tpc;
    assign br.fact_taken       = r_fact_taken;
    assign br.predict_dir_fail = r_dir_fail;
    assign br.predict_add_fail = r_add_fail;
    assign br.redirect_valid   = r_redirect_valid;
    assign br.redirect_pc      = r_redirect_pc;
    assign br.br_cnt           = r_br_cnt;
    assign br.miss_cnt         = r_miss_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed scenarios plus a randomized run for branch_resolve. A small
//   reference model tracks whether fetch is on a wrong path and which PC is
//   the correct one, and predicts the update bundle and counters.
// ----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int CW = 6;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    logic clk;
    logic rstn;

    branch_resolve_if #(.CNT_WIDTH(CW)) bif ();

    branch_resolve #(.CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .br   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Reference model state
    logic          m_wrong;
    logic [31:0]   m_good;
    logic          m_fv;
    logic [31:0]   m_fpc;
    logic [31:0]   m_ftpc;
    logic          m_ftaken;
    logic          m_dir;
    logic          m_add;
    logic          m_rv;
    logic [31:0]   m_rpc;
    logic [CW-1:0] m_br;
    logic [CW-1:0] m_miss;

    task automatic model_reset();
        m_wrong = 1'b0; m_good = '0;
        m_fv = 1'b0; m_fpc = '0; m_ftpc = '0; m_ftaken = 1'b0;
        m_dir = 1'b0; m_add = 1'b0; m_rv = 1'b0; m_rpc = '0;
        m_br = '0; m_miss = '0;
    endtask

    function automatic logic model_kill();
        return m_wrong && bif.ex_valid && (bif.ex_pc != m_good);
    endfunction

    // One clock edge of the reference: uses the inputs held across the edge.
    task automatic model_edge();
        logic        taken, resolve, miss;
        logic [31:0] fall, nxt;
        resolve = bif.ex_valid && bif.ex_ready && !model_kill();
        taken   = (bif.ex_btype == 2'b01) || (bif.ex_btype == 2'b11) ||
                  (bif.ex_btype == 2'b10 && bif.ex_cond);
        fall    = (bif.ex_pc & 32'hFFFF_FFF8) + 32'd8;
        nxt     = taken ? bif.ex_target : fall;
        // Wrong if the direction was wrong or fetch went somewhere else.
        miss    = (taken != bif.ex_pred_taken) || (bif.ex_pred_pc != nxt);
        m_fv = resolve;
        m_ftaken = resolve && taken;
        m_dir = resolve && (taken != bif.ex_pred_taken);
        m_add = resolve && taken && (bif.ex_pred_pc != bif.ex_target);
        m_rv = resolve && miss;
        if (resolve) begin
            m_fpc = bif.ex_pc;
            m_ftpc = bif.ex_target;
            if (bif.ex_btype != 2'b00 && m_br != CMAX) m_br = m_br + 1'b1;
            if (miss) begin
                if (m_miss != CMAX) m_miss = m_miss + 1'b1;
                m_rpc = nxt;
                m_wrong = 1'b1;
                m_good = nxt;
            end else begin
                m_wrong = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic [31:0] pc,
                         input logic [1:0] bt, input logic c, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ppc);
        @(negedge clk);
        bif.ex_valid = v; bif.ex_ready = r; bif.ex_pc = pc; bif.ex_btype = bt;
        bif.ex_cond = c; bif.ex_target = tgt; bif.ex_pred_taken = pt;
        bif.ex_pred_pc = ppc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(1'b1, 1'b1, 32'h1C00_0040, 2'b01, 1'b0, 32'h1C00_0400, 1'b0, 32'h1C00_0048);
        model_reset();
        @(posedge clk); #1;
        n_tests++;
        if (bif.fact_valid !== 1'b0 || bif.redirect_valid !== 1'b0 || bif.fact_pc !== 32'h0 ||
            bif.redirect_pc !== 32'h0 || bif.fact_tpc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: fv=%b rv=%b fpc=%h rpc=%h ftpc=%h, required all 0",
                     bif.fact_valid, bif.redirect_valid, bif.fact_pc, bif.redirect_pc, bif.fact_tpc);
        end
        n_tests++;
        if (bif.br_cnt !== '0 || bif.miss_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: br=%0d miss=%0d, required 0 0", bif.br_cnt, bif.miss_cnt);
        end
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_kill: got %b, required 0", bif.ex_kill);
        end
        drive(1'b0, 1'b0, '0, 2'b00, 1'b0, '0, 1'b0, '0);
        rstn = 1'b1;
    endtask

    task automatic test_correct_taken();
        drive(1'b1, 1'b1, 32'h1C00_0010, 2'b10, 1'b1, 32'h1C00_0100, 1'b1, 32'h1C00_0100);
        cycle();
        n_tests++;
        if ({bif.fact_valid, bif.fact_taken, bif.predict_dir_fail, bif.predict_add_fail,
             bif.redirect_valid} !== 5'b11000) begin
            n_fail++;
            $display("FAIL taken_flags: fv,ft,df,af,rv=%b%b%b%b%b, required 11000", bif.fact_valid,
                     bif.fact_taken, bif.predict_dir_fail, bif.predict_add_fail, bif.redirect_valid);
        end
        n_tests++;
        if (bif.fact_pc !== 32'h1C00_0010 || bif.fact_tpc !== 32'h1C00_0100) begin
            n_fail++;
            $display("FAIL taken_pcs: fpc=%h ftpc=%h, required 1c000010 1c000100",
                     bif.fact_pc, bif.fact_tpc);
        end
        n_tests++;
        if (bif.br_cnt !== 6'd1 || bif.miss_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL taken_counts: br=%0d miss=%0d, required 1 0", bif.br_cnt, bif.miss_cnt);
        end
        drive(1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        n_tests++;
        if (bif.fact_valid !== 1'b0 || bif.fact_pc !== 32'h1C00_0010) begin
            n_fail++;
            $display("FAIL idle_hold: fv=%b fpc=%h, required 0 1c000010", bif.fact_valid, bif.fact_pc);
        end
    endtask

    task automatic test_dir_miss_squash();
        drive(1'b1, 1'b1, 32'h1C00_0014, 2'b10, 1'b0, 32'h1C00_0200, 1'b1, 32'h1C00_0200);
        cycle();
        n_tests++;
        if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1C00_0018 ||
            bif.predict_dir_fail !== 1'b1 || bif.predict_add_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL dirmiss_redirect: rv=%b rpc=%h df=%b af=%b, required 1 1c000018 1 0",
                     bif.redirect_valid, bif.redirect_pc, bif.predict_dir_fail, bif.predict_add_fail);
        end
        n_tests++;
        if (bif.miss_cnt !== 6'd1 || bif.br_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL dirmiss_counts: br=%0d miss=%0d, required 2 1", bif.br_cnt, bif.miss_cnt);
        end
        drive(1'b1, 1'b1, 32'h1C00_0100, 2'b01, 1'b0, 32'h1C00_0800, 1'b0, 32'h1C00_0108);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b1) begin
            n_fail++;
            $display("FAIL squash_kill: got %b, required 1", bif.ex_kill);
        end
        cycle();
        n_tests++;
        if (bif.fact_valid !== 1'b0 || bif.redirect_valid !== 1'b0 || bif.br_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL squash_noupdate: fv=%b rv=%b br=%0d, required 0 0 2",
                     bif.fact_valid, bif.redirect_valid, bif.br_cnt);
        end
        drive(1'b1, 1'b1, 32'h1C00_0018, 2'b00, 1'b0, 32'h0, 1'b0, 32'h1C00_0020);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_match_kill: got %b, required 0", bif.ex_kill);
        end
        cycle();
        n_tests++;
        if (bif.fact_valid !== 1'b1 || bif.redirect_valid !== 1'b0 || bif.fact_pc !== 32'h1C00_0018) begin
            n_fail++;
            $display("FAIL squash_match_resolve: fv=%b rv=%b fpc=%h, required 1 0 1c000018",
                     bif.fact_valid, bif.redirect_valid, bif.fact_pc);
        end
    endtask

    task automatic test_target_miss();
        drive(1'b1, 1'b1, 32'h1C00_0020, 2'b11, 1'b0, 32'h1C00_2000, 1'b1, 32'h1C00_1000);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_after_squash_kill: got %b, required 0", bif.ex_kill);
        end
        cycle();
        n_tests++;
        if (bif.predict_add_fail !== 1'b1 || bif.predict_dir_fail !== 1'b0 ||
            bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1C00_2000 ||
            bif.miss_cnt !== 6'd2) begin
            n_fail++;
            $display("FAIL target_miss: af=%b df=%b rv=%b rpc=%h miss=%0d, required 1 0 1 1c002000 2",
                     bif.predict_add_fail, bif.predict_dir_fail, bif.redirect_valid,
                     bif.redirect_pc, bif.miss_cnt);
        end
        drive(1'b1, 1'b1, 32'h1C00_2000, 2'b00, 1'b0, 32'h0, 1'b0, 32'h1C00_2008);
        cycle();
        n_tests++;
        if (bif.fact_valid !== 1'b1 || bif.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL target_recover: fv=%b rv=%b, required 1 0", bif.fact_valid, bif.redirect_valid);
        end
    endtask

    task automatic test_stall();
        logic [CW-1:0] miss0;
        miss0 = bif.miss_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h1C00_0400, 2'b01, 1'b0, 32'h1C00_0800, 1'b0, 32'h1C00_0408);
            cycle();
            n_tests++;
            if (bif.redirect_valid !== 1'b0 || bif.fact_valid !== 1'b0 || bif.miss_cnt !== miss0) begin
                n_fail++;
                $display("FAIL stall_%0d: rv=%b fv=%b miss=%0d, required 0 0 %0d",
                         i, bif.redirect_valid, bif.fact_valid, bif.miss_cnt, miss0);
            end
        end
        drive(1'b1, 1'b1, 32'h1C00_0400, 2'b01, 1'b0, 32'h1C00_0800, 1'b0, 32'h1C00_0408);
        cycle();
        n_tests++;
        if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1C00_0800 ||
            bif.miss_cnt !== miss0 + 1'b1) begin
            n_fail++;
            $display("FAIL stall_fire: rv=%b rpc=%h miss=%0d, required 1 1c000800 %0d",
                     bif.redirect_valid, bif.redirect_pc, bif.miss_cnt, miss0 + 1'b1);
        end
        drive(1'b0, 1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle();
        n_tests++;
        if (bif.redirect_valid !== 1'b0 || bif.miss_cnt !== miss0 + 1'b1) begin
            n_fail++;
            $display("FAIL stall_single_pulse: rv=%b miss=%0d, required 0 %0d",
                     bif.redirect_valid, bif.miss_cnt, miss0 + 1'b1);
        end
    endtask

    task automatic test_mispred_on_exp();
        drive(1'b1, 1'b1, 32'h1C00_0800, 2'b10, 1'b1, 32'h1C00_0A00, 1'b0, 32'h1C00_0808);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL exp_kill: got %b, required 0", bif.ex_kill);
        end
        cycle();
        n_tests++;
        if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1C00_0A00 || bif.fact_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL exp_redirect: rv=%b rpc=%h ft=%b, required 1 1c000a00 1",
                     bif.redirect_valid, bif.redirect_pc, bif.fact_taken);
        end
        drive(1'b1, 1'b0, 32'h1C00_0800, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b1) begin
            n_fail++;
            $display("FAIL exp_old_pc_kill: got %b, required 1", bif.ex_kill);
        end
        cycle();
        drive(1'b1, 1'b0, 32'h1C00_0A00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h1C00_0A08);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL exp_new_pc_kill: got %b, required 0", bif.ex_kill);
        end
        cycle();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 32'h1C00_0A00, 2'b00, 1'b0, 32'h0, 1'b0, 32'h1C00_0A08);
        cycle();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC, 2'b10, 1'b0, 32'h1234_5678, 1'b1, 32'h1234_5678);
        cycle();
        n_tests++;
        if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_fall: rv=%b rpc=%h, required 1 00000000", bif.redirect_valid, bif.redirect_pc);
        end
    endtask

    task automatic test_async_reset();
        // Enter SQUASH first so reset is seen mid-squash.
        drive(1'b1, 1'b1, 32'h0000_0000, 2'b01, 1'b0, 32'h0000_4000, 1'b0, 32'h0000_0008);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if (bif.fact_valid !== 1'b0 || bif.fact_pc !== 32'h0 || bif.fact_tpc !== 32'h0 ||
            bif.redirect_pc !== 32'h0 || bif.br_cnt !== '0 || bif.miss_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: fv=%b fpc=%h ftpc=%h rpc=%h br=%0d miss=%0d, required all 0",
                     bif.fact_valid, bif.fact_pc, bif.fact_tpc, bif.redirect_pc, bif.br_cnt, bif.miss_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        drive(1'b1, 1'b1, 32'h1C00_0100, 2'b00, 1'b0, 32'h0, 1'b0, 32'h1C00_0108);
        #1;
        n_tests++;
        if (bif.ex_kill !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_kill: got %b, required 0", bif.ex_kill);
        end
        cycle();
        n_tests++;
        if (bif.fact_valid !== 1'b1 || bif.redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_resolve: fv=%b rv=%b, required 1 0", bif.fact_valid, bif.redirect_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, tgt, ppc;
        logic        bad;
        for (int i = 0; i < 400; i++) begin
            pc  = {20'h1C000, 10'($urandom), 2'b00};
            if (m_wrong && ($urandom_range(0, 1) == 0)) pc = m_good;
            tgt = {20'h1C000, 10'($urandom), 2'b00};
            case ($urandom_range(0, 2))
                0: ppc = tgt;
                1: ppc = (pc & 32'hFFFF_FFF8) + 32'd8;
                default: ppc = {20'h1C000, 10'($urandom), 2'b00};
            endcase
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0, pc,
                  2'($urandom), 1'($urandom), tgt, 1'($urandom), ppc);
            #1;
            n_tests++;
            if (bif.ex_kill !== model_kill()) begin
                n_fail++;
                $display("FAIL rand_kill[%0d]: got %b, required %b", i, bif.ex_kill, model_kill());
            end
            cycle();
            bad = (bif.fact_valid !== m_fv) || (bif.fact_taken !== m_ftaken) ||
                  (bif.predict_dir_fail !== m_dir) || (bif.predict_add_fail !== m_add) ||
                  (bif.redirect_valid !== m_rv) || (bif.redirect_pc !== m_rpc) ||
                  (bif.fact_pc !== m_fpc) || (bif.fact_tpc !== m_ftpc);
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL rand_bundle[%0d]: fv%b ft%b df%b af%b rv%b rpc=%h fpc=%h ftpc=%h, required fv%b ft%b df%b af%b rv%b rpc=%h fpc=%h ftpc=%h",
                         i, bif.fact_valid, bif.fact_taken, bif.predict_dir_fail, bif.predict_add_fail,
                         bif.redirect_valid, bif.redirect_pc, bif.fact_pc, bif.fact_tpc,
                         m_fv, m_ftaken, m_dir, m_add, m_rv, m_rpc, m_fpc, m_ftpc);
            end
            n_tests++;
            if (bif.br_cnt !== m_br || bif.miss_cnt !== m_miss) begin
                n_fail++;
                $display("FAIL rand_counts[%0d]: br=%0d miss=%0d, required %0d %0d",
                         i, bif.br_cnt, bif.miss_cnt, m_br, m_miss);
            end
        end
        n_tests++;
        if (bif.br_cnt !== CMAX) begin
            n_fail++;
            $display("FAIL saturation: br=%0d, required %0d", bif.br_cnt, CMAX);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        bif.ex_valid = 1'b0; bif.ex_ready = 1'b0; bif.ex_pc = '0; bif.ex_btype = '0;
        bif.ex_cond = 1'b0; bif.ex_target = '0; bif.ex_pred_taken = 1'b0; bif.ex_pred_pc = '0;
        model_reset();
        test_reset();
        test_correct_taken();
        test_dir_miss_squash();
        test_target_miss();
        test_stall();
        test_mispred_on_exp();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
